genesis_pad_scan_sched: RTL and testbench

Poll scheduler for the two Genesis gamepad reader instances on the board. Each frame it issues one 8-step read burst, interleaving single-cycle step enables between port 0 and port 1 so that each SELECT edge gets a full settle interval. After the burst it snapshots both readers' decoded buttons and pad types into stable registers for the core. It then idles past the 6-button pad's internal counter timeout.

---
 rtl/genesis_pad_scan_sched.sv | 145 ++++++++++++++
 tb/tb_genesis_pad_scan_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/genesis_pad_scan_sched.sv
// genesis_pad_scan_sched: per-frame poll scheduler for two Genesis pad readers.
// Issues one interleaved 16-strobe burst per frame (pad0 on even steps, pad1 on odd),
// then latches both readers' decoded buttons and pad types into stable snapshots.
module genesis_pad_scan_sched #(
  parameter int unsigned STEP_CYCLES  = 500,
  parameter int unsigned STEPS        = 8,
  parameter int unsigned FRAME_CYCLES = 100000
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iENABLE,
  input  logic [11:0] iPAD0_DECODED,
  input  logic [11:0] iPAD1_DECODED,
  input  logic [1:0]  iPAD0_TYPE,
  input  logic [1:0]  iPAD1_TYPE,
  output logic        oPAD0_STEP,
  output logic        oPAD1_STEP,
  output logic [11:0] oPAD0_STATE,
  output logic [11:0] oPAD1_STATE,
  output logic [1:0]  oPAD0_TYPE,
  output logic [1:0]  oPAD1_TYPE,
  output logic        oFRAME_DONE,
  output logic        oBUSY
);

  localparam int unsigned CW = $clog2(FRAME_CYCLES);
  localparam int unsigned IW = $clog2(2 * STEPS);
  localparam int unsigned WW = $clog2(STEP_CYCLES);

  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(2 * STEPS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(STEP_CYCLES - 2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STEP    = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  generate
    if (STEPS != 8) begin : g_bad_steps
      $error("STEPS must be 8 to match the reader's 8-state cycle");
    end
    if (STEP_CYCLES < 2) begin : g_bad_step_cycles
      $error("STEP_CYCLES must be at least 2");
    end
    if (FRAME_CYCLES <= 2 * STEPS * STEP_CYCLES + 2) begin : g_bad_frame
      $error("FRAME_CYCLES must exceed 2*STEPS*STEP_CYCLES+2");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [WW-1:0] r_wait;
  logic [1:0]    r_state;
  logic [11:0]   r_state0;
  logic [11:0]   r_state1;
  logic [1:0]    r_type0;
  logic [1:0]    r_type1;
  logic          r_done;
  logic          w_frame_start;
  logic          w_in_step;

  assign w_frame_start = (r_cnt == '0) && iENABLE;
  assign w_in_step     = (r_state == S_STEP);

  // Free-running frame counter, independent of the scan FSM.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Burst sequencer: one step strobe, then STEP_CYCLES-1 settle cycles, 2*STEPS times.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_frame_start) begin
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            if (r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_state <= S_CAPTURE;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= S_STEP;
            end
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_CAPTURE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Snapshot registers and frame-done pulse, loaded only from the CAPTURE cycle.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state0 <= '0;
      r_state1 <= '0;
      r_type0  <= '0;
      r_type1  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_CAPTURE);
      if (r_state == S_CAPTURE) begin
        r_state0 <= iPAD0_DECODED;
        r_state1 <= iPAD1_DECODED;
        r_type0  <= iPAD0_TYPE;
        r_type1  <= iPAD1_TYPE;
      end
    end
  end

  assign oPAD0_STEP  = w_in_step & ~r_idx[0];
  assign oPAD1_STEP  = w_in_step &  r_idx[0];
  assign oBUSY       = (r_state == S_STEP) || (r_state == S_WAIT);
  assign oFRAME_DONE = r_done;
  assign oPAD0_STATE = r_state0;
  assign oPAD1_STATE = r_state1;
  assign oPAD0_TYPE  = r_type0;
  assign oPAD1_TYPE  = r_type1;

endmodule

// File: tb/tb_genesis_pad_scan_sched.sv
// Scoreboard bench for genesis_pad_scan_sched: a frame-level model predicts strobe,
// frame-done and snapshot events into a queue; a monitor checks the DUT every cycle.
module tb_genesis_pad_scan_sched;

  localparam int SC    = 4;
  localparam int NST   = 8;
  localparam int FRAME = 100;
  localparam int BURST = 2 * NST * SC;
  localparam int NONE  = -1000000;

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b1;
  logic        iENABLE = 1'b0;
  logic [11:0] iPAD0_DECODED = '0;
  logic [11:0] iPAD1_DECODED = '0;
  logic [1:0]  iPAD0_TYPE = '0;
  logic [1:0]  iPAD1_TYPE = '0;
  logic        oPAD0_STEP, oPAD1_STEP, oFRAME_DONE, oBUSY;
  logic [11:0] oPAD0_STATE, oPAD1_STATE;
  logic [1:0]  oPAD0_TYPE, oPAD1_TYPE;

  genesis_pad_scan_sched #(
    .STEP_CYCLES (SC),
    .STEPS       (NST),
    .FRAME_CYCLES(FRAME)
  ) dut (
    .iCLK         (iCLK),
    .iRESET       (iRESET),
    .iENABLE      (iENABLE),
    .iPAD0_DECODED(iPAD0_DECODED),
    .iPAD1_DECODED(iPAD1_DECODED),
    .iPAD0_TYPE   (iPAD0_TYPE),
    .iPAD1_TYPE   (iPAD1_TYPE),
    .oPAD0_STEP   (oPAD0_STEP),
    .oPAD1_STEP   (oPAD1_STEP),
    .oPAD0_STATE  (oPAD0_STATE),
    .oPAD1_STATE  (oPAD1_STATE),
    .oPAD0_TYPE   (oPAD0_TYPE),
    .oPAD1_TYPE   (oPAD1_TYPE),
    .oFRAME_DONE  (oFRAME_DONE),
    .oBUSY        (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // kind: 0 = pad0 strobe, 1 = pad1 strobe, 2 = frame done with snapshot
  typedef struct {
    int          cyc;
    int          kind;
    logic [11:0] s0;
    logic [1:0]  t0;
    logic [11:0] s1;
    logic [1:0]  t1;
  } ev_t;

  ev_t q[$];

  int n_tot = 0;
  int n_pass = 0;
  int cyc_n = 0;
  int m_cnt = 0;
  int m_S = NONE;
  bit mon_en = 1'b0;
  logic [11:0] x_s0 = '0, x_s1 = '0;
  logic [1:0]  x_t0 = '0, x_t1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
    else
      n_pass++;
  endtask

  // Frame-level reference: bursts start the cycle after counter==0 with enable in idle.
  task automatic model_eval();
    ev_t e;
    bit idle;
    if (iRESET) begin
      q.delete();
      m_S    = NONE;
      m_cnt  = 0;
      x_s0   = '0; x_s1 = '0; x_t0 = '0; x_t1 = '0;
      mon_en = 1'b1;
    end else begin
      idle = !(m_S != NONE && cyc_n >= m_S && cyc_n <= m_S + BURST);
      if (idle && m_cnt == 0 && iENABLE) begin
        m_S = cyc_n + 1;
        for (int k = 0; k < NST; k++) begin
          e = '{cyc: m_S + 2 * k * SC, kind: 0, s0: '0, t0: '0, s1: '0, t1: '0};
          q.push_back(e);
          e = '{cyc: m_S + (2 * k + 1) * SC, kind: 1, s0: '0, t0: '0, s1: '0, t1: '0};
          q.push_back(e);
        end
      end
      if (m_S != NONE && cyc_n == m_S + BURST) begin
        e = '{cyc: cyc_n + 1, kind: 2, s0: iPAD0_DECODED, t0: iPAD0_TYPE,
              s1: iPAD1_DECODED, t1: iPAD1_TYPE};
        q.push_back(e);
      end
      m_cnt = (m_cnt + 1) % FRAME;
    end
  endtask

  task automatic tick();
    #6;
    model_eval();
    @(posedge iCLK);
    #1;
    cyc_n++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_inputs();
    iPAD0_DECODED = 12'($urandom);
    iPAD1_DECODED = 12'($urandom);
    iPAD0_TYPE    = 2'($urandom);
    iPAD1_TYPE    = 2'($urandom);
  endtask

  // Monitor: consume all events due this cycle and compare against DUT outputs.
  initial begin
    ev_t e;
    logic e0, e1, ed, eb;
    forever begin
      @(negedge iCLK);
      if (mon_en) begin
        e0 = 1'b0; e1 = 1'b0; ed = 1'b0;
        while (q.size() > 0 && q[0].cyc < cyc_n) begin
          n_tot++;
          $display("FAIL stale_event cycle %0d: event kind %0d due at %0d never consumed",
                   cyc_n, q[0].kind, q[0].cyc);
          void'(q.pop_front());
        end
        while (q.size() > 0 && q[0].cyc == cyc_n) begin
          e = q.pop_front();
          case (e.kind)
            0: e0 = 1'b1;
            1: e1 = 1'b1;
            default: begin
              ed = 1'b1;
              x_s0 = e.s0; x_t0 = e.t0; x_s1 = e.s1; x_t1 = e.t1;
            end
          endcase
        end
        eb = (m_S != NONE) && (cyc_n >= m_S) && (cyc_n < m_S + BURST);
        chk("pad0_step",  32'(oPAD0_STEP),  32'(e0));
        chk("pad1_step",  32'(oPAD1_STEP),  32'(e1));
        chk("step_excl",  32'(oPAD0_STEP & oPAD1_STEP), 32'(0));
        chk("frame_done", 32'(oFRAME_DONE), 32'(ed));
        chk("busy",       32'(oBUSY),       32'(eb));
        chk("pad0_state", 32'(oPAD0_STATE), 32'(x_s0));
        chk("pad1_state", 32'(oPAD1_STATE), 32'(x_s1));
        chk("pad0_type",  32'(oPAD0_TYPE),  32'(x_t0));
        chk("pad1_type",  32'(oPAD1_TYPE),  32'(x_t1));
      end
    end
  end

  initial begin
    @(posedge iCLK);
    #1;
    // Reset release with enable high and known pad values, then values cleared.
    iRESET = 1'b1; iENABLE = 1'b1;
    iPAD0_DECODED = 12'hA5F; iPAD0_TYPE = 2'd2;
    iPAD1_DECODED = 12'h003; iPAD1_TYPE = 2'd1;
    ticks(3);
    iRESET = 1'b0;
    ticks(80);
    iPAD0_DECODED = '0; iPAD0_TYPE = '0;
    iPAD1_DECODED = '0; iPAD1_TYPE = '0;
    ticks(110);

    // Enable low at counter 0, raised mid-frame: first burst waits for next frame.
    iRESET = 1'b1; ticks(2);
    iRESET = 1'b0; iENABLE = 1'b0; rand_inputs();
    ticks(30);
    iENABLE = 1'b1;
    ticks(110);

    // Enable dropped mid-burst: burst completes, next frame skipped.
    iRESET = 1'b1; ticks(1);
    iRESET = 1'b0; iENABLE = 1'b1; rand_inputs();
    ticks(20);
    iENABLE = 1'b0;
    ticks(130);

    // Reset mid-burst aborts it and restarts the frame counter.
    iRESET = 1'b1; ticks(1);
    iRESET = 1'b0; iENABLE = 1'b1; rand_inputs();
    ticks(30);
    iRESET = 1'b1; ticks(2);
    iRESET = 1'b0;
    ticks(130);

    // Randomized enable, pad data and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      iRESET = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 149) == 0) iENABLE = ~iENABLE;
      if ($urandom_range(0, 29) == 0) rand_inputs();
      tick();
    end

    iRESET = 1'b0; iENABLE = 1'b0;
    ticks(2 * FRAME);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
